apb_slave: RTL and testbench

Parameterised APB (AMBA 3) completer with an internal word-addressed memory and a configurable number of wait states per transfer. Sits behind a single APB requester on the peripheral bus and serves as the memory-mapped storage target in the subsystem. Supports single and back-to-back reads and writes with PREADY-based wait-state insertion.

---
 rtl/apb_slave_pkg.sv | 19 +
 rtl/apb_slave_mem.sv | 43 ++++
 rtl/apb_slave.sv | 110 +++++++++++
 tb/tb_apb_slave.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/apb_slave_pkg.sv
// apb_slave_pkg: shared FSM state type and default geometry for the APB completer.
package apb_slave_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   localparam int DEF_ADDR_WIDTH  = 8;
   localparam int DEF_DATA_WIDTH  = 32;
   localparam int DEF_WAIT_CYCLES = 0;

   // Width needed to count 0..n inclusive; at least one bit so zero-wait builds stay legal.
   function automatic int cnt_width(input int n);
      return (n > 0) ? $clog2(n + 1) : 1;
   endfunction

endpackage

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: single-port word memory, synchronous write, combinational read.
// Build option: APB_SLAVE_MEM_RESET_EN clears every word while reset is asserted;
// without it the array has no reset and powers up undefined.
module apb_slave_mem
   import apb_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

`ifdef APB_SLAVE_MEM_RESET_EN
   // Write port; reset wipes the whole array to zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end
`else
   logic w_unused_rst;
   assign w_unused_rst = i_rst;

   // Write port; contents survive reset.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
   end
`endif

   assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/apb_slave.sv
// apb_slave: APB3 completer fronting apb_slave_mem, with WAIT_CYCLES_COUNT
// wait states per transfer. Memory reset is selected by APB_SLAVE_MEM_RESET_EN
// (see apb_slave_mem). PRESETn is active HIGH despite its name.
module apb_slave
   import apb_slave_pkg::*;
#(
   parameter int WAIT_CYCLES_COUNT = DEF_WAIT_CYCLES,
   parameter int ADDR_WIDTH        = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   input  logic [ADDR_WIDTH-1:0] PADDR,
   input  logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PWRITE,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   output logic [DATA_WIDTH-1:0] PRDATA,
   output logic                  PREADY
);

   localparam int            CW        = cnt_width(WAIT_CYCLES_COUNT);
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES_COUNT);

   state_t                r_state;
   state_t                w_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_write;
   logic                  w_latch;
   logic                  w_mem_we;
   logic [DATA_WIDTH-1:0] w_mem_rdata;

   // Phase decode, next state and PREADY. SETUP is recognised combinationally
   // from IDLE so it lines up with the requester's setup cycle; that keeps a
   // transfer at 2 + WAIT_CYCLES_COUNT cycles and lets a completion hand
   // straight over to the next setup with no idle cycle.
   always_comb begin
      w_state     = r_state;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_latch     = 1'b0;
      PREADY      = 1'b0;
      if (r_state == IDLE && PSEL && !PENABLE) w_state = SETUP;
      case (w_state)
         IDLE: begin
            // PSEL & PENABLE with no setup phase is ignored here.
            w_state_nxt = IDLE;
         end
         SETUP: begin
            w_state_nxt = ACCESS;
            w_latch     = 1'b1;
            w_cnt_nxt   = '0;
         end
         ACCESS: begin
            PREADY = PSEL && PENABLE && (r_cnt == WAIT_LAST);
            if (!PSEL || PREADY) begin
               // Completion, or requester abandoned the transfer.
               w_state_nxt = IDLE;
            end else if (r_cnt < WAIT_LAST) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // State and wait-counter registers.
   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Capture transfer attributes in the setup phase; later bus changes are ignored.
   always_ff @(posedge PCLK or posedge PRESETn) begin
      if (PRESETn) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_write <= 1'b0;
      end else if (w_latch) begin
         r_addr  <= PADDR;
         r_wdata <= PWDATA;
         r_write <= PWRITE;
      end
   end

   assign w_mem_we = PREADY && r_write;
   assign PRDATA   = (PREADY && !r_write) ? w_mem_rdata : '0;

   apb_slave_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mem (
      .i_clk   (PCLK),
      .i_rst   (PRESETn),
      .i_we    (w_mem_we),
      .i_addr  (r_addr),
      .i_wdata (r_wdata),
      .o_rdata (w_mem_rdata)
   );

endmodule

// File: tb/tb_apb_slave.sv
// tb_apb_slave: two completers (0 and 3 wait states) driven by randomized and
// directed APB traffic; a negedge monitor compares against a word-array model.
module tb_apb_slave;

   localparam int WC[2] = '{0, 3};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        psel[2], penable[2], pwrite[2], pready[2];
   logic [7:0]  paddr[2];
   logic [31:0] pwdata[2], prdata[2];

   logic [31:0] mdl[2][256];
   bit          wrt[2][256];
   logic [31:0] q0[$], q1[$];
   bit          viol[2];
   int          acc_n[2];
   int          npass = 0, ntot = 0, tmo = 0;
   bit          fin = 0, fin_done = 0;

   always #5 clk = ~clk;

   apb_slave #(.WAIT_CYCLES_COUNT(0), .ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut0 (
      .PCLK(clk), .PRESETn(rst), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PWRITE(pwrite[0]),
      .PSEL(psel[0]), .PENABLE(penable[0]), .PRDATA(prdata[0]), .PREADY(pready[0]));

   apb_slave #(.WAIT_CYCLES_COUNT(3), .ADDR_WIDTH(8), .DATA_WIDTH(32)) u_dut1 (
      .PCLK(clk), .PRESETn(rst), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PWRITE(pwrite[1]),
      .PSEL(psel[1]), .PENABLE(penable[1]), .PRDATA(prdata[1]), .PREADY(pready[1]));

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
   endtask

   // Model of memory reset: only the cleared build defines contents after reset.
   task automatic model_reset();
`ifdef APB_SLAVE_MEM_RESET_EN
      for (int k = 0; k < 2; k++)
         for (int a = 0; a < 256; a++) begin
            mdl[k][a] = '0;
            wrt[k][a] = 1'b1;
         end
`endif
   endtask

   // Monitor / scoreboard: every negedge, per DUT.
   logic [31:0] e;
   int          qn;
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            chk("rst_pready", k, 32'(pready[k]), 32'd0);
            chk("rst_prdata", k, prdata[k], 32'd0);
            acc_n[k] = 0;
         end else if (viol[k]) begin
            chk("viol_pready", k, 32'(pready[k]), 32'd0);
            chk("viol_prdata", k, prdata[k], 32'd0);
         end else if (psel[k] && penable[k]) begin
            acc_n[k]++;
            if (pready[k]) begin
               chk("latency", k, 32'(acc_n[k]), 32'(WC[k] + 1));
               acc_n[k] = 0;
               if (!pwrite[k]) begin
                  qn = (k == 0) ? q0.size() : q1.size();
                  if (qn == 0) chk("rd_unexpected", k, 32'(qn), 32'd1);
                  else begin
                     e = (k == 0) ? q0.pop_front() : q1.pop_front();
                     chk("rdata", k, prdata[k], e);
                  end
               end else begin
                  chk("wr_prdata", k, prdata[k], 32'd0);
               end
            end else begin
               chk("wait_prdata", k, prdata[k], 32'd0);
            end
         end else begin
            chk("idle_pready", k, 32'(pready[k]), 32'd0);
            chk("idle_prdata", k, prdata[k], 32'd0);
            acc_n[k] = 0;
         end
      end
      if (fin && !fin_done) begin
         chk("timeouts", 0, 32'(tmo), 32'd0);
         chk("q_empty", 0, 32'(q0.size()), 32'd0);
         chk("q_empty", 1, 32'(q1.size()), 32'd0);
         fin_done = 1;
      end
   end

   // One APB transfer; abort_n > 0 drops PSEL after that many access cycles.
   task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input int abort_n);
      int n;
      bit done, ok, aborted;
      if (!wr) begin
         if (k == 0) q0.push_back(mdl[0][a]);
         else        q1.push_back(mdl[1][a]);
      end
      psel[k] = 1; penable[k] = 0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
      @(posedge clk); #1;
      penable[k] = 1;
      n = 0; done = 0; ok = 0; aborted = 0;
      while (!done) begin
         @(negedge clk);
         n++;
         ok = pready[k];
         @(posedge clk); #1;
         if (ok) done = 1;
         else if (abort_n > 0 && n == abort_n) begin aborted = 1; done = 1; end
         else if (n > 40) begin tmo++; done = 1; end
         else begin
            paddr[k]  = 8'($urandom);
            pwdata[k] = $urandom;
         end
      end
      psel[k] = 0; penable[k] = 0;
      if (aborted) begin @(posedge clk); #1; end
      if (wr && ok) begin mdl[k][a] = d; wrt[k][a] = 1; end
   endtask

   logic [7:0] ra;
   bit         rw;
   initial begin
      for (int k = 0; k < 2; k++) begin
         psel[k] = 0; penable[k] = 0; pwrite[k] = 0; paddr[k] = 0; pwdata[k] = 0;
         viol[k] = 0; acc_n[k] = 0;
         for (int a = 0; a < 256; a++) begin mdl[k][a] = '0; wrt[k][a] = 0; end
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 0;

      for (int k = 0; k < 2; k++) begin
         xfer(k, 1, 8'h04, 32'hDEADBEEF, 0);
         xfer(k, 0, 8'h04, 32'h0, 0);
         xfer(k, 1, 8'hFF, 32'h12345678, 0);
         @(posedge clk); #1;
         xfer(k, 0, 8'hFF, 32'h0, 0);
         // back-to-back, no idle
         xfer(k, 1, 8'h01, 32'h11, 0);
         xfer(k, 1, 8'h02, 32'h22, 0);
         xfer(k, 0, 8'h01, 32'h0, 0);
         xfer(k, 0, 8'h02, 32'h0, 0);
         // protocol violation from IDLE must not write
         psel[k] = 1; penable[k] = 1; pwrite[k] = 1; paddr[k] = 8'h04; pwdata[k] = 32'hFFFFFFFF;
         viol[k] = 1;
         repeat (3) begin @(posedge clk); #1; end
         psel[k] = 0; penable[k] = 0;
         @(posedge clk); #1;
         viol[k] = 0;
         xfer(k, 0, 8'h04, 32'h0, 0);
      end

      // abort during wait states leaves memory untouched
      xfer(1, 1, 8'h08, 32'h5555AAAA, 0);
      xfer(1, 1, 8'h08, 32'hCAFEF00D, 2);
      xfer(1, 0, 8'h08, 32'h0, 0);

      // randomized mix with random gaps
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom_range(31));
            rw = ($urandom_range(1) == 1) || !wrt[k][ra];
            xfer(k, rw, ra, $urandom, 0);
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
         end

      // reset in the middle of a zero-wait write's access cycle
      psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 8'h04; pwdata[0] = 32'h0BADF00D;
      @(posedge clk); #1;
      penable[0] = 1;
      #2 rst = 1;
      @(posedge clk); #1;
      psel[0] = 0; penable[0] = 0; rst = 0;
      model_reset();
      xfer(0, 0, 8'h04, 32'h0, 0);
      xfer(1, 0, 8'h04, 32'h0, 0);
`ifdef APB_SLAVE_MEM_RESET_EN
      xfer(0, 0, 8'h10, 32'h0, 0);
`endif

      @(posedge clk); #1;
      fin = 1;
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
